// File: rtl/wb_stage.sv
// Writeback stage: takes one execute/LSU result, waits for load data when needed,
// formats it, writes the register file and retires the instruction.
module wb_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_pc,
  input  logic [4:0]  in_rd,
  input  logic        in_rd_wen,
  input  logic [63:0] in_result,
  input  logic        in_is_load,
  input  logic [2:0]  in_ld_funct3,
  input  logic [2:0]  in_ld_offset,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [63:0] rf_wdata,
  output logic        commit_valid,
  output logic [63:0] commit_pc,
  output logic [63:0] instret,
  output logic        err_flag
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [63:0] r_pc;
  logic [4:0]  r_rd;
  logic        r_rd_wen;
  logic [63:0] r_result;
  logic        r_is_load;
  logic [2:0]  r_funct3;
  logic [2:0]  r_offset;
  logic [63:0] r_instret;
  logic        r_err;

  logic        w_accept;
  logic        w_mem_take;
  logic        w_err_set;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_word;
  logic [63:0] w_ld_data;

  assign in_ready   = (r_state != WAIT_MEM);
  assign w_accept   = in_valid && in_ready;
  assign w_mem_take = (r_state == WAIT_MEM) && mem_rvalid;

  // Lane select by offset; bits below the access size simply drop out.
  assign w_byte = mem_rdata[{r_offset, 3'b000} +: 8];
  assign w_half = mem_rdata[{r_offset[2:1], 4'b0000} +: 16];
  assign w_word = r_offset[2] ? mem_rdata[63:32] : mem_rdata[31:0];

  always_comb begin
    w_ld_data = 64'd0;
    case (r_funct3)
      3'b000:  w_ld_data = {{56{w_byte[7]}}, w_byte};
      3'b001:  w_ld_data = {{48{w_half[15]}}, w_half};
      3'b010:  w_ld_data = {{32{w_word[31]}}, w_word};
      3'b011:  w_ld_data = mem_rdata;
      3'b100:  w_ld_data = {56'd0, w_byte};
      3'b101:  w_ld_data = {48'd0, w_half};
      3'b110:  w_ld_data = {32'd0, w_word};
      default: w_ld_data = 64'd0;
    endcase
  end

  assign w_err_set = (mem_rvalid && (r_state != WAIT_MEM)) ||
                     (w_mem_take && (r_funct3 == 3'b111));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (w_accept) w_state_next = in_is_load ? WAIT_MEM : WRITE;
      WAIT_MEM: if (mem_rvalid) w_state_next = WRITE;
      WRITE:    w_state_next = w_accept ? (in_is_load ? WAIT_MEM : WRITE) : IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pc      <= 64'd0;
      r_rd      <= 5'd0;
      r_rd_wen  <= 1'b0;
      r_result  <= 64'd0;
      r_is_load <= 1'b0;
      r_funct3  <= 3'd0;
      r_offset  <= 3'd0;
      r_instret <= 64'd0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_pc      <= in_pc;
        r_rd      <= in_rd;
        r_rd_wen  <= in_rd_wen;
        r_result  <= in_result;
        r_is_load <= in_is_load;
        r_funct3  <= in_ld_funct3;
        r_offset  <= in_ld_offset;
      end else if (w_mem_take) begin
        r_result <= w_ld_data;
      end
      if (r_state == WRITE) r_instret <= r_instret + 64'd1;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  always_comb begin
    rf_wen       = 1'b0;
    rf_waddr     = 5'd0;
    rf_wdata     = 64'd0;
    commit_valid = 1'b0;
    commit_pc    = 64'd0;
    if (r_state == WRITE) begin
      rf_wen       = r_rd_wen && (r_rd != 5'd0);
      rf_waddr     = r_rd;
      rf_wdata     = r_result;
      commit_valid = 1'b1;
      commit_pc    = r_pc;
    end
  end

  assign instret  = r_instret;
  assign err_flag = r_err;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by randomized
// transactions compared against a transaction-level reference model.
module tb_wb_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic [63:0] in_result;
  logic        in_is_load;
  logic [2:0]  in_ld_funct3;
  logic [2:0]  in_ld_offset;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic [63:0] instret;
  logic        err_flag;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] m_instret;
  logic        m_err;

  always #5 clock = ~clock;

  wb_stage dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_rd(in_rd),
    .in_rd_wen(in_rd_wen), .in_result(in_result), .in_is_load(in_is_load),
    .in_ld_funct3(in_ld_funct3), .in_ld_offset(in_ld_offset),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .instret(instret), .err_flag(err_flag)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference load formatting using the language's own signed/unsigned types.
  function automatic logic [63:0] exp_load(input logic [2:0] f3, input logic [2:0] off,
                                           input logic [63:0] d);
    byte     b;
    shortint h;
    int      w;
    b = byte'(d >> (8 * off));
    h = shortint'(d >> (8 * (off & 3'd6)));
    w = int'(d >> (32 * off[2]));
    case (f3)
      3'd0:    return 64'(longint'(b));
      3'd1:    return 64'(longint'(h));
      3'd2:    return 64'(longint'(w));
      3'd3:    return d;
      3'd4:    return {56'd0, b};
      3'd5:    return {48'd0, h};
      3'd6:    return {32'd0, w};
      default: return 64'd0;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; mem_rvalid = 1'b0;
    tick();
    tick();
    check("rst_ready", in_ready, 1);
    check("rst_instret", instret, 0);
    check("rst_err", err_flag, 0);
    check("rst_rf_wen", rf_wen, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_commit", commit_valid, 0);
    check("rst_commit_pc", commit_pc, 0);
    reset = 1'b0;
    m_instret = 64'd0;
    m_err = 1'b0;
  endtask

  task automatic drive(input logic [63:0] pc, input logic [4:0] rd, input logic wen,
                       input logic [63:0] res, input logic ld, input logic [2:0] f3,
                       input logic [2:0] off);
    in_valid = 1'b1; in_pc = pc; in_rd = rd; in_rd_wen = wen; in_result = res;
    in_is_load = ld; in_ld_funct3 = f3; in_ld_offset = off;
  endtask

  // Issues one instruction in the current cycle and returns in its commit cycle,
  // so a following call gives back-to-back issue.
  task automatic do_txn(input logic [63:0] pc, input logic [4:0] rd, input logic wen,
                        input logic [63:0] res, input logic ld, input logic [2:0] f3,
                        input logic [2:0] off, input logic [63:0] rdata, input int lat);
    logic [63:0] exp;
    check("acc_ready", in_ready, 1);
    check("acc_err", err_flag, m_err);
    drive(pc, rd, wen, res, ld, f3, off);
    mem_rvalid = 1'b0;
    tick();
    in_valid = 1'b0;
    if (ld) begin
      for (int i = 1; i <= lat; i++) begin
        check("wait_ready", in_ready, 0);
        check("wait_commit", commit_valid, 0);
        check("wait_rf_wen", rf_wen, 0);
        mem_rvalid = (i == lat);
        mem_rdata  = (i == lat) ? rdata : ~rdata;
        tick();
      end
      mem_rvalid = 1'b0;
    end
    exp = ld ? exp_load(f3, off, rdata) : res;
    if (ld && f3 == 3'd7) m_err = 1'b1;
    check("wb_commit", commit_valid, 1);
    check("wb_rf_wen", rf_wen, (wen && rd != 5'd0));
    check("wb_waddr", rf_waddr, rd);
    check("wb_wdata", rf_wdata, exp);
    check("wb_commit_pc", commit_pc, pc);
    check("wb_instret", instret, m_instret);
    check("wb_err", err_flag, m_err);
    m_instret = m_instret + 64'd1;
    $display("txn pc=%h rd=%0d wen=%0d load=%0d f3=%0d off=%0d lat=%0d wdata=%h",
             pc, rd, wen, ld, f3, off, lat, exp);
  endtask

  task automatic idle(input int n, input logic stray);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      mem_rvalid = stray && (i == 0);
      tick();
      if (stray && i == 0) m_err = 1'b1;
    end
    mem_rvalid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_rd = '0; in_rd_wen = 1'b0;
    in_result = '0; in_is_load = 1'b0; in_ld_funct3 = '0; in_ld_offset = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    m_instret = '0; m_err = 1'b0;

    do_reset();
    do_txn(64'h8000_0000, 5'd5, 1'b1, 64'h1234, 1'b0, 3'd0, 3'd0, 64'd0, 0);
    idle(1, 1'b0);
    check("nl_instret", instret, 1);
    do_txn(64'h100, 5'd7, 1'b1, 64'hAAAA, 1'b1, 3'd0, 3'd3, 64'h0000_0000_80FF_0000, 4);
    do_txn(64'h104, 5'd8, 1'b1, 64'h0, 1'b1, 3'd5, 3'd6, 64'hBEEF_0000_0000_0000, 2);
    do_txn(64'h108, 5'd9, 1'b1, 64'h0, 1'b1, 3'd6, 3'd4, 64'hDEAD_BEEF_0000_0000, 1);
    do_txn(64'h10C, 5'd0, 1'b1, 64'hFF, 1'b0, 3'd0, 3'd0, 64'd0, 0);
    idle(2, 1'b0);

    do_reset();
    do_txn(64'h200, 5'd1, 1'b1, 64'h11, 1'b0, 3'd0, 3'd0, 64'd0, 0);
    do_txn(64'h204, 5'd2, 1'b1, 64'h22, 1'b0, 3'd0, 3'd0, 64'd0, 0);
    do_txn(64'h208, 5'd3, 1'b1, 64'h33, 1'b0, 3'd0, 3'd0, 64'd0, 0);
    idle(1, 1'b0);
    check("b2b_instret", instret, 3);

    // Reset held in WAIT_MEM, then a late response arrives.
    do_reset();
    drive(64'h300, 5'd4, 1'b1, 64'h0, 1'b1, 3'd3, 3'd0);
    tick();
    in_valid = 1'b0;
    check("wm_ready", in_ready, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h5555;
    check("rstwm_commit", commit_valid, 0);
    check("rstwm_rf_wen", rf_wen, 0);
    tick();
    mem_rvalid = 1'b0;
    check("rstwm_err", err_flag, 1);
    check("rstwm_instret", instret, 0);
    check("rstwm_commit2", commit_valid, 0);

    // Reset wins over an accept in the WRITE cycle.
    do_reset();
    do_txn(64'h400, 5'd6, 1'b1, 64'h66, 1'b0, 3'd0, 3'd0, 64'd0, 0);
    drive(64'h404, 5'd6, 1'b1, 64'h77, 1'b0, 3'd0, 3'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    check("rstwr_commit", commit_valid, 0);
    check("rstwr_rf_wen", rf_wen, 0);
    check("rstwr_instret", instret, 0);
    tick();
    m_instret = 64'd0;

    do_reset();
    for (int t = 0; t < 200; t++) begin
      logic        ld;
      logic [2:0]  f3;
      ld = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      do_txn({$urandom, $urandom}, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             {$urandom, $urandom}, ld, f3, 3'($urandom_range(0, 7)),
             {$urandom, $urandom}, $urandom_range(1, 4));
      if ($urandom_range(0, 2) != 0)
        idle($urandom_range(1, 2), ($urandom_range(0, 15) == 0));
    end
    idle(1, 1'b0);
    check("final_instret", instret, m_instret);
    check("final_err", err_flag, m_err);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
